// File: rtl/uart_tx.sv
// UART transmitter: 8N1 framing, CLKS_PER_BIT clocks per bit, registered line output.
// One frame per accepted request; requests arriving while busy are dropped.
module uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 217
) (
   input  logic       i_Clock,
   input  logic       i_Reset,
   input  logic       i_TX_DV,
   input  logic [7:0] i_TX_Byte,
   output logic       o_TX_Serial,
   output logic       o_TX_Active,
   output logic       o_TX_Done
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] START   = 3'd1;
   localparam logic [2:0] DATA    = 3'd2;
   localparam logic [2:0] STOP    = 3'd3;
   localparam logic [2:0] CLEANUP = 3'd4;

   logic [2:0]       state, state_nxt;
   logic [CNT_W-1:0] clk_count, clk_count_nxt;
   logic [2:0]       bit_index, bit_index_nxt;
   logic [7:0]       tx_data, tx_data_nxt;
   logic             serial_nxt, active_nxt, done_nxt;
   logic             bit_last;

   assign bit_last = (clk_count == CNT_LAST);

   // State and output registers; outputs are the registered image of next-state logic
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state       <= IDLE;
         clk_count   <= '0;
         bit_index   <= '0;
         tx_data     <= '0;
         o_TX_Serial <= 1'b1;
         o_TX_Active <= 1'b0;
         o_TX_Done   <= 1'b0;
      end else begin
         state       <= state_nxt;
         clk_count   <= clk_count_nxt;
         bit_index   <= bit_index_nxt;
         tx_data     <= tx_data_nxt;
         o_TX_Serial <= serial_nxt;
         o_TX_Active <= active_nxt;
         o_TX_Done   <= done_nxt;
      end
   end

   // Next-state logic; line value computed one cycle ahead so the output is a flop
   always_comb begin
      state_nxt     = state;
      clk_count_nxt = clk_count;
      bit_index_nxt = bit_index;
      tx_data_nxt   = tx_data;
      serial_nxt    = 1'b1;
      active_nxt    = 1'b0;
      done_nxt      = 1'b0;

      case (state)
         IDLE: begin
            if (i_TX_DV) begin
               tx_data_nxt   = i_TX_Byte;
               clk_count_nxt = '0;
               bit_index_nxt = '0;
               state_nxt     = START;
               serial_nxt    = 1'b0;
               active_nxt    = 1'b1;
            end
         end

         START: begin
            active_nxt = 1'b1;
            serial_nxt = 1'b0;
            if (bit_last) begin
               clk_count_nxt = '0;
               state_nxt     = DATA;
               serial_nxt    = tx_data[0];
            end else begin
               clk_count_nxt = clk_count + CNT_W'(1);
            end
         end

         DATA: begin
            active_nxt = 1'b1;
            serial_nxt = tx_data[bit_index];
            if (bit_last) begin
               clk_count_nxt = '0;
               if (bit_index == 3'd7) begin
                  bit_index_nxt = '0;
                  state_nxt     = STOP;
                  serial_nxt    = 1'b1;
               end else begin
                  bit_index_nxt = bit_index + 3'd1;
                  serial_nxt    = tx_data[bit_index + 3'd1];
               end
            end else begin
               clk_count_nxt = clk_count + CNT_W'(1);
            end
         end

         STOP: begin
            active_nxt = 1'b1;
            if (bit_last) begin
               clk_count_nxt = '0;
               state_nxt     = CLEANUP;
               active_nxt    = 1'b0;
               done_nxt      = 1'b1;
            end else begin
               clk_count_nxt = clk_count + CNT_W'(1);
            end
         end

         CLEANUP: begin
            state_nxt = IDLE;
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule
